// File: rtl/sound_pkg.sv
// Shared definitions for the sound effects block.
//   state_t     : sequencer states (IDLE, TONE, LOST_HI, LOST_LO)
//   PRIO_*      : event priorities, higher value wins
//   HP_*        : square-wave half-periods in clock cycles
//   block_hp()  : half-period for a destroyed block, from its row
package sound_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TONE    = 2'd1,
        LOST_HI = 2'd2,
        LOST_LO = 2'd3
    } state_t;

    localparam logic [1:0] PRIO_WALL   = 2'd0;
    localparam logic [1:0] PRIO_PADDLE = 2'd1;
    localparam logic [1:0] PRIO_BLOCK  = 2'd2;
    localparam logic [1:0] PRIO_LOST   = 2'd3;

    localparam logic [17:0] HP_WALL       = 18'd56818;   // 440 Hz
    localparam logic [17:0] HP_PADDLE     = 18'd28409;   // 880 Hz
    localparam logic [17:0] HP_BLOCK_BASE = 18'd7500;    // row 0, 3.33 kHz
    localparam logic [17:0] HP_BLOCK_STEP = 18'd2500;    // per row further down
    localparam logic [17:0] HP_LOST_HI    = 18'd113636;
    localparam logic [17:0] HP_LOST_LO    = 18'd227272;

    // Lower rows sound lower: row 7 gives 25000 cycles (1 kHz).
    function automatic logic [17:0] block_hp(input logic [2:0] row);
        return HP_BLOCK_BASE + HP_BLOCK_STEP * 18'(row);
    endfunction

endpackage

// File: rtl/sound_effects_if.sv
// Event and audio signals between the game logic and the sound block.
//   HIT_WALL, HIT_PADDLE, HIT_BLOCK, BALL_LOST : one-cycle event pulses
//   HIT_BLOCK_ROW : row of the destroyed block, valid with HIT_BLOCK
//   MUTE          : level, silences SPEAKER only
//   SPEAKER       : square-wave audio
//   BUSY          : high while a sound is sequencing
//   DBG_STATE     : current sequencer state, for observation only
// Handshake: events are fire-and-forget pulses with no ready/back-pressure;
// the sound block either takes a pulse in the cycle it is high or drops it.
interface sound_effects_if;
    import sound_pkg::*;

    logic       HIT_WALL;
    logic       HIT_PADDLE;
    logic       HIT_BLOCK;
    logic [2:0] HIT_BLOCK_ROW;
    logic       BALL_LOST;
    logic       MUTE;
    logic       SPEAKER;
    logic       BUSY;
    state_t     DBG_STATE;

    modport master (
        output HIT_WALL, HIT_PADDLE, HIT_BLOCK, HIT_BLOCK_ROW, BALL_LOST, MUTE,
        input  SPEAKER, BUSY, DBG_STATE
    );

    modport slave (
        input  HIT_WALL, HIT_PADDLE, HIT_BLOCK, HIT_BLOCK_ROW, BALL_LOST, MUTE,
        output SPEAKER, BUSY, DBG_STATE
    );

endinterface

// File: rtl/sound_effects_tone_gen.sv
// Square-wave divider.
//   clk, rst_n  : clock, asynchronous active-low reset
//   load        : restart the wave high with a new half-period
//   half_period : cycles spent at each level
//   enable      : keep running; when low the divider parks at 0
//   level       : wave output
module tone_gen (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [17:0] half_period,
    input  logic        enable,
    output logic        level
);

    logic [17:0] hp_q;
    logic [17:0] cnt_q;

    // cnt_q counts HP-1 down to 0 at each level, so every level lasts
    // exactly HP cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hp_q  <= '0;
            cnt_q <= '0;
            level <= 1'b0;
        end else if (load) begin
            hp_q  <= half_period;
            cnt_q <= half_period - 18'd1;
            level <= 1'b1;
        end else if (enable) begin
            if (cnt_q == '0) begin
                cnt_q <= hp_q - 18'd1;
                level <= ~level;
            end else begin
                cnt_q <= cnt_q - 18'd1;
            end
        end else begin
            cnt_q <= '0;
            level <= 1'b0;
        end
    end

endmodule

// File: rtl/sound_effects.sv
// Breakout sound effects: priority arbitration of game events, tone
// sequencing and duration timing; the wave itself comes from tone_gen.
//   CLK      : clock
//   RESET_N  : asynchronous active-low reset
//   bus      : sound_effects_if.slave (events in, SPEAKER/BUSY/DBG_STATE out)
//   DUR_SHORT: wall/paddle/block tone length in cycles
//   DUR_LONG : length of each ball-lost note in cycles
module sound_effects
    import sound_pkg::*;
#(
    parameter int DUR_SHORT = 1250000,
    parameter int DUR_LONG  = 10000000
) (
    input  logic            CLK,
    input  logic            RESET_N,
    sound_effects_if.slave  bus
);

    localparam logic [23:0] DUR_SHORT_M1 = 24'(DUR_SHORT - 1);
    localparam logic [23:0] DUR_LONG_M1  = 24'(DUR_LONG - 1);

    state_t      state_q, state_d;
    logic [1:0]  prio_q, prio_d;
    logic [23:0] dur_q, dur_d;

    logic        ev_any;
    logic [1:0]  ev_prio;
    state_t      ev_state;
    logic [17:0] ev_hp;
    logic        last_cycle;
    logic        seq_done;
    logic        accept;
    logic        load;
    logic [17:0] load_hp;
    logic        level;

    // Pick the single highest-priority event of this cycle.
    always_comb begin
        ev_any   = bus.BALL_LOST | bus.HIT_BLOCK | bus.HIT_PADDLE | bus.HIT_WALL;
        ev_prio  = PRIO_WALL;
        ev_state = TONE;
        ev_hp    = HP_WALL;
        if (bus.BALL_LOST) begin
            ev_prio  = PRIO_LOST;
            ev_state = LOST_HI;
            ev_hp    = HP_LOST_HI;
        end else if (bus.HIT_BLOCK) begin
            ev_prio  = PRIO_BLOCK;
            ev_hp    = block_hp(bus.HIT_BLOCK_ROW);
        end else if (bus.HIT_PADDLE) begin
            ev_prio  = PRIO_PADDLE;
            ev_hp    = HP_PADDLE;
        end
    end

    // dur_q runs DUR-1 down to 0, so 0 marks the last cycle of a note.
    // In the final cycle of a whole sound the block counts as free, so any
    // event is taken rather than lost to the return to IDLE.
    assign last_cycle = (dur_q == '0);
    assign seq_done   = last_cycle && (state_q == TONE || state_q == LOST_LO);
    assign accept     = ev_any && (state_q == IDLE || seq_done || ev_prio >= prio_q);

    // State register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            prio_q  <= PRIO_WALL;
            dur_q   <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            dur_q   <= dur_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        dur_d   = dur_q;
        load    = 1'b0;
        load_hp = ev_hp;
        if (accept) begin
            state_d = ev_state;
            prio_d  = ev_prio;
            dur_d   = (ev_state == LOST_HI) ? DUR_LONG_M1 : DUR_SHORT_M1;
            load    = 1'b1;
        end else if (state_q != IDLE) begin
            if (last_cycle) begin
                case (state_q)
                    LOST_HI: begin
                        // Second note keeps priority 3 and restarts the phase.
                        state_d = LOST_LO;
                        dur_d   = DUR_LONG_M1;
                        load    = 1'b1;
                        load_hp = HP_LOST_LO;
                    end
                    default: begin
                        state_d = IDLE;
                        prio_d  = PRIO_WALL;
                        dur_d   = '0;
                    end
                endcase
            end else begin
                dur_d = dur_q - 24'd1;
            end
        end
    end

    tone_gen u_tone_gen (
        .clk         (CLK),
        .rst_n       (RESET_N),
        .load        (load),
        .half_period (load_hp),
        .enable      (state_q != IDLE),
        .level       (level)
    );

    // Outputs: all from registered state; MUTE only gates the audio.
    always_comb begin
        bus.BUSY      = (state_q != IDLE);
        bus.SPEAKER   = level && (state_q != IDLE) && !bus.MUTE;
        bus.DBG_STATE = state_q;
    end

endmodule
